// File: rtl/alu_writeback_seq.sv
// Execute/writeback sequencer: reads Rn then Rm from the register file, shifts Rm,
// applies the ALU op, registers the result and status, then writes the result to Rd.
module alu_writeback_seq #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [1:0]        opcode_i,
  input  logic [1:0]        shift_i,
  input  logic [ADDR_W-1:0] rn_i,
  input  logic [ADDR_W-1:0] rm_i,
  input  logic [ADDR_W-1:0] rd_i,
  output logic [ADDR_W-1:0] r_addr_o,
  input  logic [DATA_W-1:0] r_data_i,
  output logic [ADDR_W-1:0] w_addr_o,
  output logic [DATA_W-1:0] w_data_o,
  output logic              w_en_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [2:0]        status_o
);

  typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, EXEC, WB} state_e;

  localparam logic [1:0] OP_ADD = 2'b00, OP_SUB = 2'b01, OP_AND = 2'b10;
  localparam logic [1:0] SH_LSL = 2'b01, SH_LSR = 2'b10, SH_ASR = 2'b11;

  state_e            state_q, state_d;
  logic [1:0]        opcode_q, shift_q;
  logic [ADDR_W-1:0] rn_q, rm_q, rd_q;
  logic [DATA_W-1:0] a_q, b_q, c_q;
  logic [2:0]        status_q;
  logic              done_q;

  logic [DATA_W-1:0] b_sh, alu_res;
  logic              alu_v;

  // Barrel-free single-position shifter on operand B followed by the ALU.
  always_comb begin
    b_sh    = b_q;
    alu_res = '0;
    alu_v   = 1'b0;
    case (shift_q)
      SH_LSL:  b_sh = {b_q[DATA_W-2:0], 1'b0};
      SH_LSR:  b_sh = {1'b0, b_q[DATA_W-1:1]};
      SH_ASR:  b_sh = {b_q[DATA_W-1], b_q[DATA_W-1:1]};
      default: b_sh = b_q;
    endcase
    case (opcode_q)
      OP_ADD: begin
        alu_res = a_q + b_sh;
        alu_v   = (a_q[DATA_W-1] == b_sh[DATA_W-1]) && (alu_res[DATA_W-1] != a_q[DATA_W-1]);
      end
      OP_SUB: begin
        alu_res = a_q - b_sh;
        alu_v   = (a_q[DATA_W-1] != b_sh[DATA_W-1]) && (alu_res[DATA_W-1] != a_q[DATA_W-1]);
      end
      OP_AND:  alu_res = a_q & b_sh;
      default: alu_res = ~b_sh;
    endcase
  end

  // Next-state and state-decoded outputs; the sequence is strictly linear.
  always_comb begin
    state_d  = state_q;
    r_addr_o = '0;
    w_en_o   = 1'b0;
    case (state_q)
      IDLE:    if (start_i) state_d = LOAD_A;
      LOAD_A: begin
        r_addr_o = rn_q;
        state_d  = LOAD_B;
      end
      LOAD_B: begin
        r_addr_o = rm_q;
        state_d  = EXEC;
      end
      EXEC:    state_d = WB;
      WB: begin
        w_en_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register plus operand capture, result/status update and done pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      opcode_q <= '0;
      shift_q  <= '0;
      rn_q     <= '0;
      rm_q     <= '0;
      rd_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      status_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == WB);
      if (state_q == IDLE && start_i) begin
        opcode_q <= opcode_i;
        shift_q  <= shift_i;
        rn_q     <= rn_i;
        rm_q     <= rm_i;
        rd_q     <= rd_i;
      end
      if (state_q == LOAD_A) a_q <= r_data_i;
      if (state_q == LOAD_B) b_q <= r_data_i;
      if (state_q == EXEC) begin
        c_q      <= alu_res;
        status_q <= {(alu_res == '0), alu_res[DATA_W-1], alu_v};
      end
    end
  end

  assign busy_o   = (state_q != IDLE);
  assign done_o   = done_q;
  assign status_o = status_q;
  assign w_addr_o = rd_q;
  assign w_data_o = c_q;

endmodule
